// File: rtl/vga_fill_master.sv
// Avalon-MM master that fills a clipped screen rectangle one pixel write at a time,
// in raster order with x fastest, and stalls on waitrequest.
module vga_fill_master #(
  parameter int          SCREEN_W      = 160,
  parameter int          SCREEN_H      = 120,
  parameter logic [3:0]  VGA_WORD_ADDR = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  x0,
  input  logic [6:0]  y0,
  input  logic [7:0]  x1,
  input  logic [6:0]  y1,
  input  logic [7:0]  colour,
  output logic        busy,
  output logic        done,
  output logic [14:0] pix_count,
  output logic [3:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_MAX = 7'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, FIN} state_t;
  state_t state, state_nx;

  logic [7:0] xs, xe, cx, col;
  logic [6:0] ys, ye, cy;
  logic [7:0] x1_clip;
  logic [6:0] y1_clip;
  logic       empty, accept, last_pix;

  // x0 > X_MAX also covers an origin that is already off-screen.
  always_comb begin
    x1_clip  = (x1 > X_MAX) ? X_MAX : x1;
    y1_clip  = (y1 > Y_MAX) ? Y_MAX : y1;
    empty    = (x0 > x1_clip) || (y0 > y1_clip) || (x0 > X_MAX) || (y0 > Y_MAX);
    accept   = (state == FILL) && !m_waitrequest;
    last_pix = (cx >= xe) && (cy >= ye);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = empty ? FIN : FILL;
      FILL:    if (accept && last_pix) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    m_write     = (state == FILL);
    busy        = (state != IDLE);
    done        = (state == FIN);
    m_address   = VGA_WORD_ADDR;
    m_writedata = {1'b0, cy, cx, 8'h00, col};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xs <= '0; ys <= '0; xe <= '0; ye <= '0;
      cx <= '0; cy <= '0; col <= '0;
      pix_count <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        xs        <= x0;
        ys        <= y0;
        xe        <= x1_clip;
        ye        <= y1_clip;
        col       <= colour;
        cx        <= x0;
        cy        <= y0;
        pix_count <= '0;
      end
    end else if (accept) begin
      if (pix_count != 15'h7FFF) pix_count <= pix_count + 15'd1;
      if (cx < xe) begin
        cx <= cx + 8'd1;
      end else if (cy < ye) begin
        cx <= xs;
        cy <= cy + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_fill_master.sv
// Randomised bench for vga_fill_master: a queue-based raster model supplies
// every expected write, the timing of done and the final pixel count.
module tb_vga_fill_master;
  logic        clk = 1'b0;
  logic        reset, start, busy, done, m_write, m_waitrequest;
  logic [7:0]  x0, x1, colour;
  logic [6:0]  y0, y1;
  logic [14:0] pix_count;
  logic [3:0]  m_address;
  logic [31:0] m_writedata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] fd, ld;

  vga_fill_master dut (
    .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .colour(colour), .busy(busy), .done(done), .pix_count(pix_count),
    .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: all on-screen pixels of the rectangle, clipped, in raster order.
  task automatic build_exp(input int ax0, input int ay0, input int ax1, input int ay1,
                           input logic [7:0] c);
    int xe, ye;
    exp_q.delete();
    if (ax0 < 160 && ay0 < 120) begin
      xe = (ax1 < 159) ? ax1 : 159;
      ye = (ay1 < 119) ? ay1 : 119;
      for (int y = ay0; y <= ye; y++)
        for (int x = ax0; x <= xe; x++)
          exp_q.push_back({1'b0, 7'(y), 8'(x), 8'h00, c});
    end
  endtask

  // stall_mode: 0 none, 1 random, 2 three stall cycles on the second write
  task automatic run_op(input int ax0, input int ay0, input int ax1, input int ay1,
                        input logic [7:0] c, input int stall_mode, input bit poke,
                        output logic [31:0] first_d, output logic [31:0] last_d);
    int cyc, idx, wcyc, nstall, stall_left, n;
    bit got_done, wr;
    build_exp(ax0, ay0, ax1, ay1, c);
    n = exp_q.size();
    first_d = '0; last_d = '0;
    @(negedge clk);
    x0 = 8'(ax0); y0 = 7'(ay0); x1 = 8'(ax1); y1 = 7'(ay1); colour = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x0 = 8'($urandom); y0 = 7'($urandom); x1 = 8'($urandom); y1 = 7'($urandom);
    colour = 8'($urandom);
    cyc = 1; idx = 0; wcyc = 0; nstall = 0; stall_left = 3; got_done = 1'b0;
    while (cyc < 40000) begin
      wr = 1'b0;
      if (stall_mode == 1) wr = ($urandom_range(3) == 0);
      else if (stall_mode == 2 && idx == 1 && stall_left > 0) begin
        wr = 1'b1; stall_left--;
      end
      m_waitrequest = wr;
      if (poke && cyc == 3) begin
        start = 1'b1; x0 = 8'd0; y0 = 7'd0; x1 = 8'd159; y1 = 7'd119;
      end else start = 1'b0;
      if (done) begin got_done = 1'b1; break; end
      if (m_write) begin
        wcyc++;
        if (wr) nstall++;
        if (idx < n) check("wdata", m_writedata, exp_q[idx]);
        else check("extra_write", 32'(m_write), 32'd0);
        if (!wr) begin
          if (idx == 0) first_d = m_writedata;
          last_d = m_writedata;
          idx++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    m_waitrequest = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    check("writes", 32'(idx), 32'(n));
    check("done_cycle", 32'(cyc), 32'(n + nstall + 1));
    check("fin_mwrite", 32'(m_write), 32'd0);
    check("fin_busy", 32'(busy), 32'd1);
    check("addr", 32'(m_address), 32'd0);
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("pix_count", 32'(pix_count), 32'(n));
    if (poke) begin
      repeat (3) begin
        @(negedge clk);
        check("no_restart", 32'(m_write | busy), 32'd0);
      end
    end
  endtask

  initial begin
    int rx0, ry0, rx1, ry1, guard;
    reset = 1'b1; start = 1'b0; m_waitrequest = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mwrite", 32'(m_write), 32'd0);
    check("rst_wdata", m_writedata, 32'd0);
    check("rst_pix", 32'(pix_count), 32'd0);
    reset = 1'b0;

    run_op(0, 0, 159, 119, 8'hFF, 0, 1'b0, fd, ld);
    check("fs_first", fd, 32'h000000FF);
    check("fs_last", ld, 32'h779F00FF);

    run_op(10, 5, 11, 6, 8'h80, 2, 1'b0, fd, ld);
    run_op(158, 118, 200, 127, 8'h3C, 1, 1'b0, fd, ld);
    run_op(20, 0, 10, 5, 8'h11, 0, 1'b0, fd, ld);
    run_op(170, 3, 180, 4, 8'h22, 0, 1'b0, fd, ld);
    run_op(30, 40, 37, 42, 8'h5A, 1, 1'b1, fd, ld);

    for (int k = 0; k < 10; k++) begin
      rx0 = $urandom_range(0, 175);
      ry0 = $urandom_range(0, 127);
      rx1 = rx0 + $urandom_range(0, 12) - 2;
      ry1 = ry0 + $urandom_range(0, 8) - 2;
      if (rx1 < 0) rx1 = 0;
      if (rx1 > 255) rx1 = 255;
      if (ry1 < 0) ry1 = 0;
      if (ry1 > 127) ry1 = 127;
      run_op(rx0, ry0, rx1, ry1, 8'($urandom), 1, 1'b0, fd, ld);
    end

    // Reset while the fifth write is on the bus.
    @(negedge clk);
    x0 = 8'd0; y0 = 7'd0; x1 = 8'd9; y1 = 7'd9; colour = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(m_write && pix_count == 15'd4) && guard < 50) begin
      @(negedge clk); guard++;
    end
    check("rst_mid_reach", 32'(guard < 50), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_mwrite", 32'(m_write), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_pix", 32'(pix_count), 32'd0);
    reset = 1'b0;
    run_op(50, 60, 50, 60, 8'h99, 0, 1'b0, fd, ld);

    // start coincident with reset is lost
    @(negedge clk);
    reset = 1'b1; start = 1'b1; x0 = 8'd1; y0 = 7'd1; x1 = 8'd5; y1 = 7'd5;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_mwrite", 32'(m_write), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
